// File: rtl/turret_pkg.sv
// turret_pkg - shared types and constants for the turret aiming controller.
//
// Contents:
//   cmd_t             steering command decoded from the keycode (NONE, CCW, CW)
//   state_t           key auto-repeat FSM states (IDLE, PRESS, REPEAT)
//   aim_entry_t       one aiming table row: bullet motion override + spawn pixel
//   aim_table_t       full aiming table, always MAX_ANGLES rows deep
//   DEFAULT_AIM_TABLE nine-position table; rows 9..15 are unused and zero
//   decode_cmd()      keycode -> cmd_t helper
package turret_pkg;

    localparam int MAX_ANGLES = 16;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CCW  = 2'd1,
        CW   = 2'd2
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Motion components are two's complement, spawn coordinates are pixels
    typedef struct packed {
        logic [9:0] motion_x;
        logic [9:0] motion_y;
        logic [9:0] spawn_x;
        logic [9:0] spawn_y;
    } aim_entry_t;

    typedef aim_entry_t [0:MAX_ANGLES-1] aim_table_t;

    localparam aim_table_t DEFAULT_AIM_TABLE = '{
        '{10'h000, 10'h3FF, 10'd558, 10'd422},
        '{10'h3FF, 10'h3FE, 10'd549, 10'd414},
        '{10'h3FF, 10'h3FF, 10'd550, 10'd415},
        '{10'h3FE, 10'h3FF, 10'd535, 10'd410},
        '{10'h3FF, 10'h000, 10'd510, 10'd420},
        '{10'h3FE, 10'h001, 10'd513, 10'd448},
        '{10'h3FF, 10'h001, 10'd514, 10'd453},
        '{10'h3FF, 10'h002, 10'd516, 10'd455},
        '{10'h000, 10'h001, 10'd545, 10'd458},
        '{10'h000, 10'h000, 10'd000, 10'd000},
        '{10'h000, 10'h000, 10'd000, 10'd000},
        '{10'h000, 10'h000, 10'd000, 10'd000},
        '{10'h000, 10'h000, 10'd000, 10'd000},
        '{10'h000, 10'h000, 10'd000, 10'd000},
        '{10'h000, 10'h000, 10'd000, 10'd000},
        '{10'h000, 10'h000, 10'd000, 10'd000}
    };

    // Any keycode that is neither steering key counts as no command
    function automatic cmd_t decode_cmd(input logic [7:0] keycode,
                                        input logic [7:0] key_ccw,
                                        input logic [7:0] key_cw);
        if (keycode == key_ccw) begin
            return CCW;
        end else if (keycode == key_cw) begin
            return CW;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/turret_aim_ctrl_if.sv
// turret_aim_ctrl_if - steering inputs and aiming outputs of turret_aim_ctrl.
//
// Signals:
//   keycode      8           current USB keycode
//   lock         1           1 = ignore all steering input
//   frame_tick   1           one-clock pulse per video frame
//   angle_idx    IDX_W       current angle index
//   angle_onehot NUM_ANGLES  one-hot decode of angle_idx
//   motion_x/y   10          bullet motion override (two's complement)
//   spawn_x/y    10          bullet spawn pixel
//   moved        1           one-cycle pulse when angle_idx changes
//
// Modports: master drives the steering inputs, slave is the controller.
interface turret_aim_ctrl_if #(
    parameter int NUM_ANGLES = 9
);
    localparam int IDX_W = $clog2(NUM_ANGLES);

    logic [7:0]            keycode;
    logic                  lock;
    logic                  frame_tick;
    logic [IDX_W-1:0]      angle_idx;
    logic [NUM_ANGLES-1:0] angle_onehot;
    logic [9:0]            motion_x;
    logic [9:0]            motion_y;
    logic [9:0]            spawn_x;
    logic [9:0]            spawn_y;
    logic                  moved;

    modport master (
        output keycode, lock, frame_tick,
        input  angle_idx, angle_onehot, motion_x, motion_y,
               spawn_x, spawn_y, moved
    );

    modport slave (
        input  keycode, lock, frame_tick,
        output angle_idx, angle_onehot, motion_x, motion_y,
               spawn_x, spawn_y, moved
    );

endinterface

// File: rtl/turret_aim_ctrl_key_repeat_fsm.sv
// key_repeat_fsm - turns a held steering command into step requests.
//
// Ports:
//   clk_i         system clock
//   rst_ni        synchronous active-low reset
//   cmd_i         decoded steering command
//   frame_tick_i  one-clock pulse per video frame (paces auto-repeat)
//   lock_i        1 = hold FSM in IDLE, never request a step
//   step_req_o    request one index step this cycle
//   step_dir_o    direction of the requested step
//
// Build option TURRET_AUTOREPEAT_EN: when defined, PRESS and REPEAT count
// frame ticks and issue repeat steps; when undefined there is no counter and
// each press produces exactly one step.
module key_repeat_fsm
    import turret_pkg::*;
#(
    parameter int REPEAT_DLY  = 12,
    parameter int REPEAT_RATE = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  cmd_t cmd_i,
    input  logic frame_tick_i,
    input  logic lock_i,
    output logic step_req_o,
    output cmd_t step_dir_o
);

    state_t state_q, state_d;
    cmd_t   prev_cmd_q;
    logic   reversal;

`ifdef TURRET_AUTOREPEAT_EN
    localparam int MAX_CNT = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;
`else
    logic unused_cfg;

    assign unused_cfg = frame_tick_i & (REPEAT_DLY != REPEAT_RATE);
`endif

    // A step always goes the way the key currently points
    assign step_dir_o = cmd_i;
    assign reversal   = (cmd_i != NONE) && (prev_cmd_q != NONE) && (cmd_i != prev_cmd_q);

    // State register; prev_cmd keeps following the key even while locked so
    // a key held through the lock does not fire on unlock
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            prev_cmd_q <= NONE;
`ifdef TURRET_AUTOREPEAT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prev_cmd_q <= cmd_i;
`ifdef TURRET_AUTOREPEAT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Next state and step request; lock, release and reversal override the
    // per-state behaviour, and a reversal beats a coincident frame tick
    always_comb begin
        state_d    = state_q;
        step_req_o = 1'b0;
`ifdef TURRET_AUTOREPEAT_EN
        cnt_d      = cnt_q;
`endif
        if (lock_i || (cmd_i == NONE)) begin
            state_d = IDLE;
`ifdef TURRET_AUTOREPEAT_EN
            cnt_d   = '0;
`endif
        end else if (reversal) begin
            step_req_o = 1'b1;
            state_d    = PRESS;
`ifdef TURRET_AUTOREPEAT_EN
            cnt_d      = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_i != prev_cmd_q) begin
                        step_req_o = 1'b1;
                        state_d    = PRESS;
`ifdef TURRET_AUTOREPEAT_EN
                        cnt_d      = '0;
`endif
                    end
                end
`ifdef TURRET_AUTOREPEAT_EN
                PRESS: begin
                    if (frame_tick_i) begin
                        if (cnt_inc == CNT_W'(REPEAT_DLY)) begin
                            step_req_o = 1'b1;
                            cnt_d      = '0;
                            state_d    = REPEAT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                REPEAT: begin
                    if (frame_tick_i) begin
                        if (cnt_inc == CNT_W'(REPEAT_RATE)) begin
                            step_req_o = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
`else
                PRESS:   state_d = PRESS;
                REPEAT:  state_d = PRESS;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/turret_aim_ctrl.sv
// turret_aim_ctrl - steps a turret through a table of firing angles from
// keyboard keycodes and drives the bullet motion override and spawn point.
//
// Ports:
//   clk_i   system clock
//   rst_ni  synchronous active-low reset
//   bus     turret_aim_ctrl_if.slave (keycode, lock, frame_tick in;
//           angle_idx, angle_onehot, motion_x/y, spawn_x/y, moved out)
//
// Build option TURRET_AUTOREPEAT_EN enables frame-tick paced auto-repeat in
// key_repeat_fsm; without it every press gives exactly one step.
module turret_aim_ctrl
    import turret_pkg::*;
#(
    parameter int         NUM_ANGLES  = 9,
    parameter int         HOME_IDX    = 4,
    parameter logic [7:0] KEY_CCW     = 8'h52,
    parameter logic [7:0] KEY_CW      = 8'h51,
    parameter bit         WRAP        = 1'b0,
    parameter int         REPEAT_DLY  = 12,
    parameter int         REPEAT_RATE = 4,
    parameter aim_table_t AIM_TABLE   = DEFAULT_AIM_TABLE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    turret_aim_ctrl_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_ANGLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ANGLES - 1);

    cmd_t             cmd;
    cmd_t             step_dir;
    logic             step_req;
    logic [IDX_W-1:0] angle_idx_q, angle_idx_d;
    logic             moved_q, moved_d;
    aim_entry_t       entry;

    assign cmd = decode_cmd(bus.keycode, KEY_CCW, KEY_CW);

    key_repeat_fsm #(
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd_i        (cmd),
        .frame_tick_i (bus.frame_tick),
        .lock_i       (bus.lock),
        .step_req_o   (step_req),
        .step_dir_o   (step_dir)
    );

    // Apply a requested step; at the end stops the step either wraps or is
    // dropped, and moved only fires when the index really changes
    always_comb begin
        angle_idx_d = angle_idx_q;
        moved_d     = 1'b0;
        if (step_req) begin
            if (step_dir == CW) begin
                if (angle_idx_q != LAST_IDX) begin
                    angle_idx_d = angle_idx_q + 1'b1;
                    moved_d     = 1'b1;
                end else if (WRAP) begin
                    angle_idx_d = '0;
                    moved_d     = 1'b1;
                end
            end else if (step_dir == CCW) begin
                if (angle_idx_q != '0) begin
                    angle_idx_d = angle_idx_q - 1'b1;
                    moved_d     = 1'b1;
                end else if (WRAP) begin
                    angle_idx_d = LAST_IDX;
                    moved_d     = 1'b1;
                end
            end
        end
    end

    // Index and moved registers; reset returns straight to the home angle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            angle_idx_q <= IDX_W'(HOME_IDX);
            moved_q     <= 1'b0;
        end else begin
            angle_idx_q <= angle_idx_d;
            moved_q     <= moved_d;
        end
    end

    // Table outputs follow the registered index with no extra latency
    assign entry            = AIM_TABLE[angle_idx_q];
    assign bus.angle_idx    = angle_idx_q;
    assign bus.angle_onehot = NUM_ANGLES'(1) << angle_idx_q;
    assign bus.motion_x     = entry.motion_x;
    assign bus.motion_y     = entry.motion_y;
    assign bus.spawn_x      = entry.spawn_x;
    assign bus.spawn_y      = entry.spawn_y;
    assign bus.moved        = moved_q;

endmodule

// File: tb/tb_turret_aim_ctrl.sv
// tb_turret_aim_ctrl - directed self-checking bench for turret_aim_ctrl.
// Two instances share clock and reset: dut (saturating) and dutWrap (wrapping).
// Build option TURRET_AUTOREPEAT_EN selects which hold-behaviour section runs.
module tb_turret_aim_ctrl;

    logic clk;
    logic rstN;
    int   vectors;
    int   miscompares;
    int   expIdx;

    turret_aim_ctrl_if #(.NUM_ANGLES(9)) bus0 ();
    turret_aim_ctrl_if #(.NUM_ANGLES(9)) bus1 ();

    turret_aim_ctrl #(
        .WRAP        (1'b0),
        .REPEAT_DLY  (8),
        .REPEAT_RATE (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus0)
    );

    turret_aim_ctrl #(
        .WRAP        (1'b1),
        .REPEAT_DLY  (8),
        .REPEAT_RATE (4)
    ) dutWrap (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus1)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n clocks and land 1 ns after the edge so outputs are stable
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the saturating instance's steering inputs for a number of clocks
    task automatic applyStimulus(input logic [7:0] key, input logic lk, input int cycles);
        bus0.keycode = key;
        bus0.lock    = lk;
        tick(cycles);
    endtask

    // One frame_tick pulse followed by two quiet clocks
    task automatic framePulse();
        bus0.frame_tick = 1'b1;
        tick(1);
        bus0.frame_tick = 1'b0;
        tick(2);
    endtask

    // Single comparison with failure accounting
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Index, one-hot and moved of the saturating instance
    task automatic checkState(input string tag, input int idx, input logic mv);
        checkOutput({tag, " idx"}, 32'(bus0.angle_idx), 32'(idx));
        checkOutput({tag, " onehot"}, 32'(bus0.angle_onehot), 32'(9'd1 << idx));
        checkOutput({tag, " moved"}, 32'(bus0.moved), 32'(mv));
    endtask

    task automatic checkAim(input string tag, input logic [9:0] mx, input logic [9:0] my,
                            input int sx, input int sy);
        checkOutput({tag, " motion_x"}, 32'(bus0.motion_x), 32'(mx));
        checkOutput({tag, " motion_y"}, 32'(bus0.motion_y), 32'(my));
        checkOutput({tag, " spawn_x"}, 32'(bus0.spawn_x), 32'(sx));
        checkOutput({tag, " spawn_y"}, 32'(bus0.spawn_y), 32'(sy));
    endtask

    // Linear sequence of directed steps
    initial begin
        vectors         = 0;
        miscompares     = 0;
        rstN            = 1'b0;
        bus0.keycode    = 8'h00;
        bus0.lock       = 1'b0;
        bus0.frame_tick = 1'b0;
        bus1.keycode    = 8'h00;
        bus1.lock       = 1'b0;
        bus1.frame_tick = 1'b0;
        $display("[TB] start");

        // Reset state: home angle 4
        tick(2);
        checkState("reset", 4, 1'b0);
        checkAim("reset", 10'h3FF, 10'h000, 510, 420);

        // Single CW tap: 4 -> 5, moved pulses for one clock
        rstN = 1'b1;
        applyStimulus(8'h00, 1'b0, 1);
        checkState("idle", 4, 1'b0);
        applyStimulus(8'h51, 1'b0, 1);
        checkState("cw tap", 5, 1'b1);
        checkAim("cw tap", 10'h3FE, 10'h001, 513, 448);
        applyStimulus(8'h00, 1'b0, 1);
        checkState("cw release", 5, 1'b0);

        // Six CCW taps from 5: 4,3,2,1,0 then suppressed at the end stop
        applyStimulus(8'h52, 1'b0, 1); checkState("ccw1", 4, 1'b1); applyStimulus(8'h00, 1'b0, 1);
        applyStimulus(8'h52, 1'b0, 1); checkState("ccw2", 3, 1'b1); applyStimulus(8'h00, 1'b0, 1);
        applyStimulus(8'h52, 1'b0, 1); checkState("ccw3", 2, 1'b1); applyStimulus(8'h00, 1'b0, 1);
        applyStimulus(8'h52, 1'b0, 1); checkState("ccw4", 1, 1'b1); applyStimulus(8'h00, 1'b0, 1);
        applyStimulus(8'h52, 1'b0, 1); checkState("ccw5", 0, 1'b1); applyStimulus(8'h00, 1'b0, 1);
        applyStimulus(8'h52, 1'b0, 1); checkState("ccw6 sat", 0, 1'b0); applyStimulus(8'h00, 1'b0, 1);
        checkAim("idx0", 10'h000, 10'h3FF, 558, 422);

        // Unrelated keycode does nothing
        applyStimulus(8'h2C, 1'b0, 2);
        checkState("other key", 0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1);

        // Eight CW taps to 8, a ninth is suppressed
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'h51, 1'b0, 1);
            applyStimulus(8'h00, 1'b0, 1);
        end
        checkState("cw to 8", 8, 1'b0);
        checkAim("idx8", 10'h000, 10'h001, 545, 458);
        applyStimulus(8'h51, 1'b0, 1);
        checkState("cw sat", 8, 1'b0);
        applyStimulus(8'h00, 1'b0, 1);

`ifdef TURRET_AUTOREPEAT_EN
        // Back to 0, then hold CW: steps at press, tick 8, 12 and 16
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h52, 1'b0, 1);
            applyStimulus(8'h00, 1'b0, 1);
        end
        checkState("rpt start", 0, 1'b0);
        applyStimulus(8'h51, 1'b0, 1);
        checkState("rpt press", 1, 1'b1);
        for (int i = 0; i < 7; i++) framePulse();
        checkState("rpt 7 ticks", 1, 1'b0);
        framePulse();
        checkState("rpt 8 ticks", 2, 1'b0);
        for (int i = 0; i < 3; i++) framePulse();
        checkState("rpt 11 ticks", 2, 1'b0);
        framePulse();
        checkState("rpt 12 ticks", 3, 1'b0);
        for (int i = 0; i < 4; i++) framePulse();
        checkState("rpt 16 ticks", 4, 1'b0);
        // Reversal: immediate step, next repeat after the full delay
        applyStimulus(8'h52, 1'b0, 1);
        checkState("reverse", 3, 1'b1);
        for (int i = 0; i < 7; i++) framePulse();
        checkState("rev 7 ticks", 3, 1'b0);
        framePulse();
        checkState("rev 8 ticks", 2, 1'b0);
        applyStimulus(8'h00, 1'b0, 1);
        expIdx = 2;
`else
        // Hold CCW: exactly one step however many frames pass
        applyStimulus(8'h52, 1'b0, 1);
        checkState("hold press", 7, 1'b1);
        for (int i = 0; i < 20; i++) framePulse();
        checkState("hold 20 ticks", 7, 1'b0);
        // Reversal while held gives one more step
        applyStimulus(8'h51, 1'b0, 1);
        checkState("hold reverse", 8, 1'b1);
        applyStimulus(8'h52, 1'b0, 1);
        checkState("hold reverse2", 7, 1'b1);
        applyStimulus(8'h00, 1'b0, 1);
        expIdx = 7;
`endif

        // Lock: pressing has no effect, key held through unlock does not step
        applyStimulus(8'h00, 1'b1, 1);
        applyStimulus(8'h51, 1'b1, 3);
        checkState("locked press", expIdx, 1'b0);
        applyStimulus(8'h51, 1'b0, 3);
        checkState("unlock held", expIdx, 1'b0);
        applyStimulus(8'h00, 1'b0, 1);
        applyStimulus(8'h51, 1'b0, 1);
        checkState("repress", expIdx + 1, 1'b1);

        // Reset while CW held: home immediately, then step on first clock out
        rstN = 1'b0;
        tick(1);
        checkState("reset held", 4, 1'b0);
        rstN = 1'b1;
        tick(1);
        checkState("after reset", 5, 1'b1);
        checkAim("after reset", 10'h3FE, 10'h001, 513, 448);
        applyStimulus(8'h00, 1'b0, 1);

        // Wrapping instance sits at home 4: four CCW taps to 0, then wrap to 8
        for (int i = 0; i < 4; i++) begin
            bus1.keycode = 8'h52; tick(1);
            bus1.keycode = 8'h00; tick(1);
        end
        checkOutput("wrap at 0 idx", 32'(bus1.angle_idx), 32'd0);
        bus1.keycode = 8'h52; tick(1);
        checkOutput("wrap down idx", 32'(bus1.angle_idx), 32'd8);
        checkOutput("wrap down moved", 32'(bus1.moved), 32'd1);
        checkOutput("wrap down spawn_x", 32'(bus1.spawn_x), 32'd545);
        checkOutput("wrap down spawn_y", 32'(bus1.spawn_y), 32'd458);
        checkOutput("wrap down onehot", 32'(bus1.angle_onehot), 32'h100);
        bus1.keycode = 8'h00; tick(1);
        bus1.keycode = 8'h51; tick(1);
        checkOutput("wrap up idx", 32'(bus1.angle_idx), 32'd0);
        checkOutput("wrap up moved", 32'(bus1.moved), 32'd1);
        checkOutput("wrap up spawn_x", 32'(bus1.spawn_x), 32'd558);
        bus1.keycode = 8'h00; tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
